ctrl_pipeline: RTL and testbench

Pipelined control unit for the five-stage MIPS core. Decodes the instruction in ID into a control bundle, carries the bundle and destination register through the ID/EX, EX/MEM and MEM/WB registers, and generates load-use stalls, jump/branch flushes and EX-stage forwarding selects. It sits beside the datapath pipeline registers and replaces per-stage ad-hoc control.

---
 rtl/ctrl_pkg.sv | 96 +++++++++
 rtl/ctrl_pipeline_hazard_unit.sv | 67 ++++++
 rtl/ctrl_pipeline.sv | 116 +++++++++++
 tb/tb_ctrl_pipeline.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-bundle type, opcode/funct constants and the instruction decoder
// for the five-stage MIPS control pipeline.
package ctrl_pkg;

    localparam int unsigned CTRL_W = 19;

    // The spare MSB pads the bundle to 19 bits; it always decodes to 0.
    typedef struct packed {
        logic       spare;
        logic [1:0] pc_src;
        logic       branch;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       alu_src1;
        logic       alu_src2;
        logic       ext_op;
        logic       lu_op;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OpRtype = 6'h00, OpJ    = 6'h02, OpJal   = 6'h03, OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08, OpAddiu = 6'h09, OpSlti = 6'h0a, OpSltiu = 6'h0b;
    localparam logic [5:0] OpAndi  = 6'h0c, OpLui  = 6'h0f, OpLw    = 6'h23, OpSw    = 6'h2b;

    localparam logic [5:0] FnSll = 6'h00, FnSrl  = 6'h02, FnSra = 6'h03, FnJr   = 6'h08;
    localparam logic [5:0] FnJalr = 6'h09, FnAdd = 6'h20, FnAddu = 6'h21, FnSub = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23, FnAnd = 6'h24, FnOr  = 6'h25, FnXor  = 6'h26;
    localparam logic [5:0] FnNor = 6'h27, FnSlt  = 6'h2a, FnSltu = 6'h2b;

    localparam logic [1:0] RdRt = 2'b00, RdRd = 2'b01, RdRa = 2'b10;
    localparam logic [1:0] WbAlu = 2'b00, WbMem = 2'b01, WbPc = 2'b10;
    localparam logic [1:0] PcSeq = 2'b00, PcJump = 2'b01, PcJr = 2'b10;
    localparam logic [1:0] FwdRf = 2'b00, FwdWb = 2'b01, FwdMem = 2'b10;

    localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluAnd = 4'd2, AluOr = 4'd3;
    localparam logic [3:0] AluXor = 4'd4, AluNor = 4'd5, AluSlt = 4'd6, AluSltu = 4'd7;
    localparam logic [3:0] AluSll = 4'd8, AluSrl = 4'd9, AluSra = 4'd10;

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (opcode)
            OpRtype: begin
                c.reg_write = 1'b1;
                c.reg_dst   = RdRd;
                case (funct)
                    FnAdd, FnAddu: c.alu_op = AluAdd;
                    FnSub, FnSubu: c.alu_op = AluSub;
                    FnAnd:  c.alu_op = AluAnd;
                    FnOr:   c.alu_op = AluOr;
                    FnXor:  c.alu_op = AluXor;
                    FnNor:  c.alu_op = AluNor;
                    FnSlt:  c.alu_op = AluSlt;
                    FnSltu: c.alu_op = AluSltu;
                    FnSll:  begin c.alu_op = AluSll; c.alu_src1 = 1'b1; end
                    FnSrl:  begin c.alu_op = AluSrl; c.alu_src1 = 1'b1; end
                    FnSra:  begin c.alu_op = AluSra; c.alu_src1 = 1'b1; end
                    FnJr:   begin c.reg_write = 1'b0; c.reg_dst = RdRt; c.pc_src = PcJr; end
                    FnJalr: begin c.pc_src = PcJr; c.mem_to_reg = WbPc; end
                    default: c = '0;
                endcase
            end
            OpLw: begin
                c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = WbMem;
                c.alu_src2  = 1'b1; c.ext_op   = 1'b1; c.alu_op     = AluAdd;
            end
            OpSw:   begin c.mem_write = 1'b1; c.alu_src2 = 1'b1; c.ext_op = 1'b1; end
            OpLui:  begin c.reg_write = 1'b1; c.alu_src2 = 1'b1; c.lu_op = 1'b1; end
            OpAddi, OpAddiu: begin
                c.reg_write = 1'b1; c.alu_src2 = 1'b1; c.ext_op = 1'b1; c.alu_op = AluAdd;
            end
            OpAndi: begin c.reg_write = 1'b1; c.alu_src2 = 1'b1; c.alu_op = AluAnd; end
            OpSlti: begin
                c.reg_write = 1'b1; c.alu_src2 = 1'b1; c.ext_op = 1'b1; c.alu_op = AluSlt;
            end
            OpSltiu: begin
                c.reg_write = 1'b1; c.alu_src2 = 1'b1; c.ext_op = 1'b1; c.alu_op = AluSltu;
            end
            OpBeq:  begin c.branch = 1'b1; c.ext_op = 1'b1; c.alu_op = AluSub; end
            OpJ:    c.pc_src = PcJump;
            OpJal:  begin
                c.pc_src = PcJump; c.reg_write = 1'b1; c.reg_dst = RdRa; c.mem_to_reg = WbPc;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OpRtype) || (opcode == OpSw) || (opcode == OpBeq);
    endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard_unit.sv
// Combinational load-use/jr stall, branch/jump flush and EX operand forwarding selects.
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter bit          FWD_EN   = 1'b1,
    parameter bit          JR_IN_ID = 1'b1
) (
    input  logic              id_valid_i,
    input  logic [1:0]        id_pc_src_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_reg_write_i,
    input  logic [REG_AW-1:0] ex_dst_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              mem_mem_read_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] mem_dst_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_dst_i,
    input  logic              ex_br_taken_i,
    output logic              pc_hold_o,
    output logic              ifid_hold_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              id_jump_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    function automatic logic hit(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (mem_reg_write_i && hit(mem_dst_i, src)) return FwdMem;
        if (wb_reg_write_i && hit(wb_dst_i, src))   return FwdWb;
        return FwdRf;
    endfunction

    logic ex_raw, mem_raw, is_j, is_jr, load_use, no_fwd, jr_stall, stall;

    always_comb begin
        ex_raw   = hit(ex_dst_i, id_rs_i) || (id_uses_rt_i && hit(ex_dst_i, id_rt_i));
        mem_raw  = hit(mem_dst_i, id_rs_i) || (id_uses_rt_i && hit(mem_dst_i, id_rt_i));
        is_j     = (id_pc_src_i == PcJump);
        is_jr    = (id_pc_src_i == PcJr);
        load_use = ex_mem_read_i && ex_raw;
        no_fwd   = !FWD_EN && ((ex_reg_write_i && ex_raw) || (mem_reg_write_i && mem_raw));
        // jr reads rs in ID, so it must wait for EX writers and for loads still in MEM.
        jr_stall = JR_IN_ID && is_jr && ((ex_reg_write_i && hit(ex_dst_i, id_rs_i)) ||
                                         (mem_mem_read_i && hit(mem_dst_i, id_rs_i)));
        stall    = id_valid_i && (load_use || no_fwd || jr_stall);

        id_jump_o     = id_valid_i && !stall && (is_j || (JR_IN_ID && is_jr));
        pc_hold_o     = stall && !ex_br_taken_i;
        ifid_hold_o   = stall && !ex_br_taken_i;
        ifid_flush_o  = ex_br_taken_i || id_jump_o;
        idex_bubble_o = ex_br_taken_i || stall;
        fwd_a_o       = FWD_EN ? fwd_sel(ex_rs_i) : FwdRf;
        fwd_b_o       = FWD_EN ? fwd_sel(ex_rt_i) : FwdRf;
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline: decodes ID into a control bundle and carries it through ID/EX, EX/MEM
// and MEM/WB alongside the destination register; hazard decisions come from hazard_unit.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter bit          FWD_EN   = 1'b1,
    parameter bit          JR_IN_ID = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              id_valid_i,
    input  logic [5:0]        id_opcode_i,
    input  logic [5:0]        id_funct_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              ex_br_taken_i,
    output logic              pc_hold_o,
    output logic              ifid_hold_o,
    output logic              ifid_flush_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [CTRL_W-1:0] mem_ctrl_o,
    output logic [CTRL_W-1:0] wb_ctrl_o,
    output logic [REG_AW-1:0] ex_dst_o,
    output logic [REG_AW-1:0] mem_dst_o,
    output logic [REG_AW-1:0] wb_dst_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              id_jump_o
);

    ctrl_t             id_ctrl, ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, wb_ctrl_q;
    logic [REG_AW-1:0] id_dst, ex_dst_q, ex_dst_d, mem_dst_q, wb_dst_q;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic              ex_valid_q, ex_valid_d, mem_valid_q, wb_valid_q, rst_q;
    logic              h_pc_hold, h_ifid_hold, h_ifid_flush, h_id_jump, idex_bubble;
    logic [1:0]        h_fwd_a, h_fwd_b;

    always_comb begin
        id_ctrl = decode_ctrl(id_opcode_i, id_funct_i);
        case (id_ctrl.reg_dst)
            RdRt:    id_dst = id_rt_i;
            RdRd:    id_dst = id_rd_i;
            RdRa:    id_dst = REG_AW'(31);
            default: id_dst = '0;
        endcase
        ex_valid_d = id_valid_i && !idex_bubble;
        ex_ctrl_d  = ex_valid_d ? id_ctrl : '0;
        ex_dst_d   = ex_valid_d ? id_dst : '0;
        ex_rs_d    = ex_valid_d ? id_rs_i : '0;
        ex_rt_d    = ex_valid_d ? id_rt_i : '0;
    end

    always_ff @(posedge clk_i) begin
        rst_q <= reset_i;
        if (reset_i) begin
            ex_valid_q  <= 1'b0; ex_ctrl_q  <= '0; ex_dst_q  <= '0;
            ex_rs_q     <= '0;   ex_rt_q    <= '0;
            mem_valid_q <= 1'b0; mem_ctrl_q <= '0; mem_dst_q <= '0;
            wb_valid_q  <= 1'b0; wb_ctrl_q  <= '0; wb_dst_q  <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;  ex_ctrl_q  <= ex_ctrl_d;  ex_dst_q  <= ex_dst_d;
            ex_rs_q     <= ex_rs_d;     ex_rt_q    <= ex_rt_d;
            mem_valid_q <= ex_valid_q;  mem_ctrl_q <= ex_ctrl_q;  mem_dst_q <= ex_dst_q;
            wb_valid_q  <= mem_valid_q; wb_ctrl_q  <= mem_ctrl_q; wb_dst_q  <= mem_dst_q;
        end
    end

    hazard_unit #(
        .REG_AW   (REG_AW),
        .FWD_EN   (FWD_EN),
        .JR_IN_ID (JR_IN_ID)
    ) u_hazard (
        .id_valid_i      (id_valid_i),
        .id_pc_src_i     (id_ctrl.pc_src),
        .id_uses_rt_i    (uses_rt(id_opcode_i)),
        .id_rs_i         (id_rs_i),
        .id_rt_i         (id_rt_i),
        .ex_mem_read_i   (ex_ctrl_q.mem_read),
        .ex_reg_write_i  (ex_ctrl_q.reg_write),
        .ex_dst_i        (ex_dst_q),
        .ex_rs_i         (ex_rs_q),
        .ex_rt_i         (ex_rt_q),
        .mem_mem_read_i  (mem_ctrl_q.mem_read),
        .mem_reg_write_i (mem_ctrl_q.reg_write),
        .mem_dst_i       (mem_dst_q),
        .wb_reg_write_i  (wb_ctrl_q.reg_write),
        .wb_dst_i        (wb_dst_q),
        .ex_br_taken_i   (ex_br_taken_i),
        .pc_hold_o       (h_pc_hold),
        .ifid_hold_o     (h_ifid_hold),
        .ifid_flush_o    (h_ifid_flush),
        .idex_bubble_o   (idex_bubble),
        .id_jump_o       (h_id_jump),
        .fwd_a_o         (h_fwd_a),
        .fwd_b_o         (h_fwd_b)
    );

    // rst_q keeps the combinational outputs quiet until the first edge after reset drops.
    always_comb begin
        pc_hold_o    = h_pc_hold && !rst_q;
        ifid_hold_o  = h_ifid_hold && !rst_q;
        ifid_flush_o = h_ifid_flush && !rst_q;
        id_jump_o    = h_id_jump && !rst_q;
        fwd_a_o      = rst_q ? FwdRf : h_fwd_a;
        fwd_b_o      = rst_q ? FwdRf : h_fwd_b;
        ex_ctrl_o    = ex_valid_q ? ex_ctrl_q : '0;
        mem_ctrl_o   = mem_valid_q ? mem_ctrl_q : '0;
        wb_ctrl_o    = wb_valid_q ? wb_ctrl_q : '0;
        ex_dst_o     = ex_valid_q ? ex_dst_q : '0;
        mem_dst_o    = mem_valid_q ? mem_dst_q : '0;
        wb_dst_o     = wb_valid_q ? wb_dst_q : '0;
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: load-use, forwarding, branch/jump flush, jr stall, reset.
module tb_ctrl_pipeline;

    logic        clk = 1'b0;
    logic        reset_i, id_valid_i, ex_br_taken_i;
    logic [5:0]  id_opcode_i, id_funct_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic        pc_hold_o, ifid_hold_o, ifid_flush_o, id_jump_o;
    logic [18:0] ex_ctrl_o, mem_ctrl_o, wb_ctrl_o;
    logic [4:0]  ex_dst_o, mem_dst_o, wb_dst_o;
    logic [1:0]  fwd_a_o, fwd_b_o;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Hand-encoded bundles: {spare,pc_src,branch,reg_write,reg_dst,mem_read,mem_write,
    // mem_to_reg,alu_src1,alu_src2,ext_op,lu_op,alu_op}
    localparam logic [18:0] CtrlLw  = 19'h04960;
    localparam logic [18:0] CtrlAdd = 19'h05000;
    localparam logic [18:0] CtrlSub = 19'h05001;
    localparam logic [18:0] CtrlJal = 19'h16200;
    localparam logic [18:0] CtrlJr  = 19'h20000;

    ctrl_pipeline #(
        .REG_AW   (5),
        .FWD_EN   (1'b1),
        .JR_IN_ID (1'b1)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .id_valid_i    (id_valid_i),
        .id_opcode_i   (id_opcode_i),
        .id_funct_i    (id_funct_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_rd_i       (id_rd_i),
        .ex_br_taken_i (ex_br_taken_i),
        .pc_hold_o     (pc_hold_o),
        .ifid_hold_o   (ifid_hold_o),
        .ifid_flush_o  (ifid_flush_o),
        .ex_ctrl_o     (ex_ctrl_o),
        .mem_ctrl_o    (mem_ctrl_o),
        .wb_ctrl_o     (wb_ctrl_o),
        .ex_dst_o      (ex_dst_o),
        .mem_dst_o     (mem_dst_o),
        .wb_dst_o      (wb_dst_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .id_jump_o     (id_jump_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid_i  = v;
        id_opcode_i = op;
        id_funct_i  = fn;
        id_rs_i     = rs;
        id_rt_i     = rt;
        id_rd_i     = rd;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset_i = 1'b1;
        ex_br_taken_i = 1'b0;
        set_id(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        chk("rst_pc_hold", pc_hold_o, 0);
        chk("rst_ifid_flush", ifid_flush_o, 0);
        chk("rst_id_jump", id_jump_o, 0);
        chk("rst_ex_ctrl", ex_ctrl_o, 0);
        chk("rst_wb_dst", wb_dst_o, 0);
        chk("rst_fwd_a", fwd_a_o, 0);
        reset_i = 1'b0;
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
        tick();

        // Load-use: lw $8,0($4) then add $9,$8,$2
        set_id(1'b1, 6'h23, 6'h00, 5'd4, 5'd8, 5'd0);
        chk("lu_no_stall_yet", pc_hold_o, 0);
        tick();
        set_id(1'b1, 6'h00, 6'h20, 5'd8, 5'd2, 5'd9);
        chk("lu_ex_ctrl_lw", ex_ctrl_o, CtrlLw);
        chk("lu_ex_dst", ex_dst_o, 8);
        chk("lu_pc_hold", pc_hold_o, 1);
        chk("lu_ifid_hold", ifid_hold_o, 1);
        tick();
        chk("lu_bubble", ex_ctrl_o, 0);
        chk("lu_mem_ctrl", mem_ctrl_o, CtrlLw);
        chk("lu_one_cycle", pc_hold_o, 0);
        tick();
        chk("lu_fwd_a_wb", fwd_a_o, 2'b01);
        chk("lu_fwd_b_rf", fwd_b_o, 2'b00);
        chk("lu_ex_ctrl_add", ex_ctrl_o, CtrlAdd);

        // EX/MEM forward: add $3,$1,$2 then sub $4,$3,$3
        set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
        tick();
        set_id(1'b1, 6'h00, 6'h22, 5'd3, 5'd3, 5'd4);
        tick();
        chk("fw_a_mem", fwd_a_o, 2'b10);
        chk("fw_b_mem", fwd_b_o, 2'b10);
        chk("fw_ex_ctrl_sub", ex_ctrl_o, CtrlSub);
        // Same pair with $0 as destination/sources
        set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(1'b1, 6'h00, 6'h22, 5'd0, 5'd0, 5'd4);
        tick();
        chk("fw_r0_a", fwd_a_o, 2'b00);
        chk("fw_r0_b", fwd_b_o, 2'b00);

        // Branch taken while a load-use stall is pending
        set_id(1'b1, 6'h23, 6'h00, 5'd6, 5'd5, 5'd0);
        tick();
        set_id(1'b1, 6'h00, 6'h20, 5'd5, 5'd5, 5'd7);
        chk("br_pre_stall", pc_hold_o, 1);
        ex_br_taken_i = 1'b1;
        #1;
        chk("br_flush", ifid_flush_o, 1);
        chk("br_pc_hold", pc_hold_o, 0);
        chk("br_ifid_hold", ifid_hold_o, 0);
        tick();
        ex_br_taken_i = 1'b0;
        #1;
        chk("br_bubble", ex_ctrl_o, 0);

        // jal in ID
        set_id(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0);
        chk("jal_id_jump", id_jump_o, 1);
        chk("jal_flush", ifid_flush_o, 1);
        chk("jal_no_hold", pc_hold_o, 0);
        tick();
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
        chk("jal_ex_dst", ex_dst_o, 31);
        tick();
        tick();
        chk("jal_wb_ctrl", wb_ctrl_o, CtrlJal);
        chk("jal_wb_dst", wb_dst_o, 31);

        // jr $31 behind addi $31,$0,4
        set_id(1'b1, 6'h08, 6'h00, 5'd0, 5'd31, 5'd0);
        tick();
        set_id(1'b1, 6'h00, 6'h08, 5'd31, 5'd0, 5'd0);
        chk("jr_stall", pc_hold_o, 1);
        chk("jr_no_jump", id_jump_o, 0);
        tick();
        chk("jr_stall_done", pc_hold_o, 0);
        chk("jr_jump", id_jump_o, 1);
        chk("jr_flush", ifid_flush_o, 1);
        tick();
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
        chk("jr_ex_ctrl", ex_ctrl_o, CtrlJr);

        // Reset in the middle of a load-use stall
        set_id(1'b1, 6'h23, 6'h00, 5'd4, 5'd8, 5'd0);
        tick();
        set_id(1'b1, 6'h00, 6'h20, 5'd8, 5'd2, 5'd9);
        chk("rs_pre_stall", pc_hold_o, 1);
        reset_i = 1'b1;
        tick();
        chk("rs_pc_hold", pc_hold_o, 0);
        chk("rs_ifid_hold", ifid_hold_o, 0);
        chk("rs_ex_ctrl", ex_ctrl_o, 0);
        chk("rs_mem_ctrl", mem_ctrl_o, 0);
        chk("rs_wb_ctrl", wb_ctrl_o, 0);
        chk("rs_mem_dst", mem_dst_o, 0);
        chk("rs_fwd_a", fwd_a_o, 0);
        reset_i = 1'b0;
        set_id(1'b1, 6'h3f, 6'h00, 5'd1, 5'd0, 5'd2);
        tick();
        chk("op3f_ex_ctrl", ex_ctrl_o, 0);
        chk("op3f_ex_dst", ex_dst_o, 0);
        set_id(1'b1, 6'h00, 6'h20, 5'd8, 5'd2, 5'd9);
        chk("post_rst_no_stall", pc_hold_o, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
